// File: rtl/common_pkg.sv
// Purpose: opcode constants shared across the pipeline.
// Contents: F6_J, the primary opcode field (instr[31:26]) of an unconditional jump.
package common_pkg;

    localparam logic [5:0] F6_J = 6'b000010;

endpackage

// File: rtl/pipes_pkg.sv
// Purpose: inter-stage payload types shared between fetch and decode.
// Contents: fetch_data_t = {pc, instruction, jump}.
package pipes_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        jump;
    } fetch_data_t;

endpackage

// File: rtl/fetch.sv
// Purpose: instruction fetch stage. Issues one instruction-bus request at a time,
//          holds the returned word for decode, and handles redirects, including
//          redirects that arrive while a request is still in flight.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   ireq_valid/addr      instruction-bus request (held until iresp_data_ok)
//   iresp_data_ok/data   instruction-bus response (one-cycle pulse)
//   fetch_enable         decode consumes fetch_data_reg this cycle
//   redirect_valid/pc    restart fetch at redirect_pc
//   fetch_valid          fetch_data_reg holds an undelivered instruction
//   fetch_data_reg       {pc, instruction, jump} toward decode
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request outstanding at ireq_addr (once out of reset)
// HOLD  | instruction held for decode, no request on the bus
// DROP  | in-flight response must be discarded, then fetch at pending target
module fetch
    import common_pkg::*;
    import pipes_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        fetch_enable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    output fetch_data_t fetch_data_reg
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic        started;
    logic [31:0] pending, pending_nxt;
    logic [31:0] addr_nxt;
    fetch_data_t data_nxt;

    // started keeps the bus quiet during reset and lets the first request
    // appear on the first edge after release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= FETCH;
            started        <= 1'b0;
            ireq_addr      <= RESET_PC;
            pending        <= RESET_PC;
            fetch_data_reg <= '0;
        end else begin
            state          <= state_nxt;
            started        <= 1'b1;
            ireq_addr      <= addr_nxt;
            pending        <= pending_nxt;
            fetch_data_reg <= data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = ireq_addr;
        pending_nxt = pending;
        data_nxt    = fetch_data_reg;
        case (state)
            FETCH: begin
                if (started) begin
                    if (redirect_valid) begin
                        if (iresp_data_ok) begin
                            addr_nxt = redirect_pc;
                        end else begin
                            // the request cannot be withdrawn; wait for it and discard
                            state_nxt   = DROP;
                            pending_nxt = redirect_pc;
                        end
                    end else if (iresp_data_ok) begin
                        state_nxt            = HOLD;
                        data_nxt.pc          = ireq_addr;
                        data_nxt.instruction = iresp_data;
                        data_nxt.jump        = (iresp_data[31:26] == F6_J);
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_nxt = FETCH;
                    addr_nxt  = redirect_pc;
                end else if (fetch_enable) begin
                    state_nxt = FETCH;
                    addr_nxt  = fetch_data_reg.pc + 32'd4;
                end
            end
            DROP: begin
                if (iresp_data_ok) begin
                    state_nxt = FETCH;
                    addr_nxt  = redirect_valid ? redirect_pc : pending;
                end else if (redirect_valid) begin
                    pending_nxt = redirect_pc;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign ireq_valid  = started && (state != HOLD);
    assign fetch_valid = (state == HOLD);

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
    import pipes_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        fetch_enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    fetch_data_t fetch_data_reg;

    int total = 0;
    int bad = 0;

    fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .fetch_enable(fetch_enable),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_valid(fetch_valid), .fetch_data_reg(fetch_data_reg)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Behavioural model: the bus either carries one request (wanted or to be
    // discarded) or decode holds one word. Only the addresses matter.
    bit          m_live = 0;     // bus request has been issued since reset
    bit          m_have = 0;     // a delivered word is waiting for decode
    bit          m_discard = 0;  // the in-flight response is unwanted
    logic [31:0] m_addr = RST_PC;
    logic [31:0] m_target = RST_PC;
    fetch_data_t m_data = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_live = 0; m_have = 0; m_discard = 0;
            m_addr = RST_PC; m_target = RST_PC; m_data = '0;
        end else if (!m_live) begin
            m_live = 1;
        end else if (m_have) begin
            if (redirect_valid) begin
                m_have = 0; m_addr = redirect_pc;
            end else if (fetch_enable) begin
                m_have = 0; m_addr = m_data.pc + 32'd4;
            end
        end else if (m_discard) begin
            if (iresp_data_ok) begin
                m_discard = 0;
                m_addr = redirect_valid ? redirect_pc : m_target;
            end else if (redirect_valid) begin
                m_target = redirect_pc;
            end
        end else if (redirect_valid) begin
            if (iresp_data_ok) m_addr = redirect_pc;
            else begin m_discard = 1; m_target = redirect_pc; end
        end else if (iresp_data_ok) begin
            m_have = 1;
            m_data.pc = m_addr;
            m_data.instruction = iresp_data;
            m_data.jump = (iresp_data[31:26] == 6'd2);
        end
    end

    always @(negedge clk) begin
        check("m_ireq_valid", 65'(ireq_valid), 65'(m_live && !m_have));
        check("m_fetch_valid", 65'(fetch_valid), 65'(m_have));
        if (m_live && !m_have) check("m_ireq_addr", 65'(ireq_addr), 65'(m_addr));
        if (m_have) check("m_fetch_data", 65'(fetch_data_reg), 65'(m_data));
    end

    task automatic step(input bit ok, input logic [31:0] d, input bit en,
                        input bit rv, input logic [31:0] rpc);
        iresp_data_ok = ok; iresp_data = d; fetch_enable = en;
        redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk); #2;
        iresp_data_ok = 0; fetch_enable = 0; redirect_valid = 0;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0);
    endtask

    initial begin
        resetn = 0;
        iresp_data_ok = 1; iresp_data = 32'h2402_0001;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ireq_valid", 65'(ireq_valid), 65'(0));
        check("rst_ireq_addr", 65'(ireq_addr), 65'(RST_PC));
        check("rst_fetch_valid", 65'(fetch_valid), 65'(0));
        check("rst_data", 65'(fetch_data_reg), 65'(0));
        iresp_data_ok = 0;
        resetn = 1;
        idle();
        check("first_req", 65'({ireq_valid, ireq_addr}), 65'({1'b1, 32'hBFC0_0000}));
        idle();
        step(1, 32'h2402_0001, 0, 0, '0);
        check("deliver1_valid", 65'(fetch_valid), 65'(1));
        check("deliver1_data", 65'(fetch_data_reg), {32'hBFC0_0000, 32'h2402_0001, 1'b0});

        for (int i = 0; i < 5; i++) begin
            idle();
            check("hold_ireq_valid", 65'(ireq_valid), 65'(0));
            check("hold_data", 65'(fetch_data_reg), {32'hBFC0_0000, 32'h2402_0001, 1'b0});
        end
        step(0, '0, 1, 0, '0);
        check("seq_addr", 65'({fetch_valid, ireq_valid, ireq_addr}), 65'({2'b01, 32'hBFC0_0004}));

        step(1, 32'h0800_0010, 0, 0, '0);
        check("jump_data", 65'(fetch_data_reg), {32'hBFC0_0004, 32'h0800_0010, 1'b1});
        step(0, '0, 1, 1, 32'h8000_0040);
        check("redir_hold", 65'({fetch_valid, ireq_valid, ireq_addr}), 65'({2'b01, 32'h8000_0040}));

        step(0, '0, 0, 1, 32'h8000_0100);
        check("drop_addr_kept", 65'({ireq_valid, ireq_addr}), 65'({1'b1, 32'h8000_0040}));
        step(0, '0, 0, 1, 32'h8000_0200);
        step(1, 32'h1234_5678, 0, 0, '0);
        check("drop_latest", 65'({fetch_valid, ireq_valid, ireq_addr}), 65'({2'b01, 32'h8000_0200}));

        step(1, 32'h1111_1111, 0, 1, 32'h8000_0300);
        check("redir_with_ok", 65'({fetch_valid, ireq_addr}), 65'({1'b0, 32'h8000_0300}));
        step(0, '0, 0, 1, 32'h8000_0400);
        step(1, 32'h2222_2222, 0, 1, 32'h8000_0500);
        check("drop_redir_ok", 65'({fetch_valid, ireq_addr}), 65'({1'b0, 32'h8000_0500}));

        step(0, '0, 0, 1, 32'hFFFF_FFFC);
        step(1, 32'h3333_3333, 0, 0, '0);
        step(1, 32'h0000_0000, 0, 0, '0);
        check("wrap_hold_pc", 65'({fetch_valid, fetch_data_reg.pc}), 65'({1'b1, 32'hFFFF_FFFC}));
        step(0, '0, 1, 0, '0);
        check("wrap_addr", 65'({fetch_valid, ireq_addr}), 65'({1'b0, 32'h0000_0000}));

        step(0, '0, 1, 0, '0);
        check("enable_ignored", 65'({fetch_valid, ireq_valid, ireq_addr}), 65'({2'b01, 32'h0}));

        resetn = 0;
        iresp_data_ok = 1; iresp_data = 32'h0800_0010;
        repeat (2) @(posedge clk);
        #2;
        check("midrst_state", 65'({ireq_valid, fetch_valid, ireq_addr}), 65'({2'b00, RST_PC}));
        iresp_data_ok = 0;
        resetn = 1;
        idle();
        check("midrst_refetch", 65'({ireq_valid, fetch_valid, ireq_addr}), 65'({2'b10, RST_PC}));
        idle();
        check("midrst_no_stale", 65'(fetch_valid), 65'(0));

        for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
